// File: rtl/voltimetro_pkg.sv
// Shared definitions for the dual-slope voltmeter: FSM states, full-scale
// count, synchroniser depth and the Moore output decode of the controller.
package voltimetro_pkg;

  typedef enum logic [2:0] {
    OCIOSO,
    ZERA,
    INTEGRA,
    DESINTEGRA,
    CARREGA
  } estado_t;

  localparam int unsigned FUNDO_ESCALA = 1000;
  localparam int unsigned PROF_SINC    = 2;

  // Bit order: {rst_s, enb, ld, ch_zr, ch_vm, ch_ref, ocupado}
  function automatic logic [6:0] decodifica(input estado_t e);
    logic [6:0] s;
    s = '0;
    case (e)
      OCIOSO:     s = 7'b000_1000;
      ZERA:       s = 7'b100_1001;
      INTEGRA:    s = 7'b010_0101;
      DESINTEGRA: s = 7'b010_0011;
      CARREGA:    s = 7'b001_0001;
      default:    s = 7'b000_1000;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/sincronizador_2ff.sv
// Multi-flop synchroniser for asynchronous comparator inputs.
module sincronizador_2ff
  import voltimetro_pkg::*;
(
  input  logic ck,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [PROF_SINC-1:0] sr_q;
  logic [PROF_SINC-1:0] sr_d;

  always_comb begin
    sr_d = {sr_q[PROF_SINC-2:0], d};
  end

  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) sr_q <= '0;
    else        sr_q <= sr_d;
  end

  assign q = sr_q[PROF_SINC-1];

endmodule

// File: rtl/controlador_dupla_rampa.sv
// Control FSM of the dual-slope integrating voltmeter: sequences auto-zero,
// integration and deintegration, and drives the BCD counter control lines.
module controlador_dupla_rampa
  import voltimetro_pkg::*;
#(
  parameter int unsigned T_ZERO   = 16,
  parameter bit          CONTINUO = 1'b0
) (
  input  logic ck,
  input  logic rst_n,
  input  logic inicio,
  input  logic Vint_z,
  input  logic cnt_max,
  output logic rst_s,
  output logic enb,
  output logic ld,
  output logic ch_zr,
  output logic ch_vm,
  output logic ch_ref,
  output logic ocupado,
  output logic ovf
);

  localparam int unsigned   TW        = $clog2(T_ZERO);
  localparam logic [TW-1:0] TIMER_FIM = TW'(T_ZERO - 1);

  estado_t       estado_q, estado_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          vz_ant_q, vz_ant_d;
  logic          ovf_q, ovf_d;
  logic [6:0]    saida_q, saida_d;
  logic          vz_sinc;
  logic          subida;

  sincronizador_2ff u_sinc (
    .ck    (ck),
    .rst_n (rst_n),
    .d     (Vint_z),
    .q     (vz_sinc)
  );

  assign subida = vz_sinc & ~vz_ant_q;

  always_comb begin
    estado_d = estado_q;
    timer_d  = '0;
    vz_ant_d = vz_sinc;
    ovf_d    = ovf_q;
    case (estado_q)
      OCIOSO: begin
        if (inicio) estado_d = ZERA;
      end
      ZERA: begin
        if (timer_q == TIMER_FIM) estado_d = INTEGRA;
        else                      timer_d  = timer_q + TW'(1);
      end
      INTEGRA: begin
        if (cnt_max) estado_d = DESINTEGRA;
      end
      DESINTEGRA: begin
        if (subida) begin
          estado_d = CARREGA;
        end else if (cnt_max) begin
          ovf_d = 1'b1;
          if (CONTINUO) estado_d = ZERA;
          else          estado_d = OCIOSO;
        end
      end
      CARREGA: begin
        if (CONTINUO) estado_d = ZERA;
        else          estado_d = OCIOSO;
      end
      default: estado_d = OCIOSO;
    endcase
    // Clear only on a normal ZERA entry, so an over-range exit straight into
    // ZERA (continuous mode) still leaves the flag visible for one conversion.
    if (estado_d == ZERA && (estado_q == OCIOSO || estado_q == CARREGA))
      ovf_d = 1'b0;
    saida_d = decodifica(estado_d);
  end

  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      estado_q <= OCIOSO;
      timer_q  <= '0;
      vz_ant_q <= 1'b0;
      ovf_q    <= 1'b0;
      saida_q  <= decodifica(OCIOSO);
    end else begin
      estado_q <= estado_d;
      timer_q  <= timer_d;
      vz_ant_q <= vz_ant_d;
      ovf_q    <= ovf_d;
      saida_q  <= saida_d;
    end
  end

  assign {rst_s, enb, ld, ch_zr, ch_vm, ch_ref, ocupado} = saida_q;
  assign ovf = ovf_q;

endmodule

// File: tb/tb_controlador_dupla_rampa.sv
// Bench for controlador_dupla_rampa: one-shot and continuous instances, each
// driving a behavioural 000-999 counter, with an integrator ramp stimulus.
module tb_controlador_dupla_rampa;

  localparam int T = 4;

  logic ck = 1'b0;
  logic rst_n = 1'b1;
  logic [1:0] inicio = '0;
  logic [1:0] vint = '0;
  logic [1:0] cmax;
  logic [1:0] rst_s_w, enb_w, ld_w, zr_w, vm_w, ref_w, ocup_w, ovf_w;

  int cnt [2] = '{0, 0};
  int latched [2] = '{0, 0};
  int ldn [2] = '{0, 0};
  int tests = 0;
  int fails = 0;

  always #5 ck = ~ck;

  controlador_dupla_rampa #(.T_ZERO(T), .CONTINUO(1'b0)) dut0 (
    .ck(ck), .rst_n(rst_n), .inicio(inicio[0]), .Vint_z(vint[0]), .cnt_max(cmax[0]),
    .rst_s(rst_s_w[0]), .enb(enb_w[0]), .ld(ld_w[0]), .ch_zr(zr_w[0]), .ch_vm(vm_w[0]),
    .ch_ref(ref_w[0]), .ocupado(ocup_w[0]), .ovf(ovf_w[0])
  );

  controlador_dupla_rampa #(.T_ZERO(T), .CONTINUO(1'b1)) dut1 (
    .ck(ck), .rst_n(rst_n), .inicio(inicio[1]), .Vint_z(vint[1]), .cnt_max(cmax[1]),
    .rst_s(rst_s_w[1]), .enb(enb_w[1]), .ld(ld_w[1]), .ch_zr(zr_w[1]), .ch_vm(vm_w[1]),
    .ch_ref(ref_w[1]), .ocupado(ocup_w[1]), .ovf(ovf_w[1])
  );

  // Responder model: decimal counter with display latch.
  assign cmax[0] = enb_w[0] && (cnt[0] == 999);
  assign cmax[1] = enb_w[1] && (cnt[1] == 999);

  always @(posedge ck) begin
    for (int i = 0; i < 2; i++) begin
      if (rst_s_w[i])    cnt[i] <= 0;
      else if (enb_w[i]) cnt[i] <= (cnt[i] + 1) % 1000;
      if (ld_w[i]) begin
        latched[i] <= cnt[i];
        ldn[i]     <= ldn[i] + 1;
      end
    end
  end

  function automatic logic [7:0] obs(input int u);
    return {rst_s_w[u], enb_w[u], ld_w[u], zr_w[u], vm_w[u], ref_w[u], ocup_w[u], ovf_w[u]};
  endfunction

  // Expected {rst_s,enb,ld,ch_zr,ch_vm,ch_ref,ocupado,ovf} r cycles after the
  // start edge: T auto-zero, 1000 integrate, then m+2 deintegrate cycles
  // (crossing plus synchroniser latency) or 1000 on over-range.
  function automatic logic [7:0] exp_vec(input int r, input int m, input bit ovr);
    int d;
    d = ovr ? 1000 : m + 2;
    if (r < T)                           return 8'b1001_0010;
    else if (r < T + 1000)               return 8'b0100_1010;
    else if (r < T + 1000 + d)           return 8'b0100_0110;
    else if (!ovr && r == T + 1000 + d)  return 8'b0010_0010;
    else                                 return {7'b0001_000, ovr};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
    tests++;
    assert (got === expv) else begin
      fails++;
      $error("FAIL %s got %0h exp %0h", tag, got, expv);
    end
  endtask

  // One conversion; m = cycles from DESINTEGRA entry until the ramp crosses zero.
  task automatic conv(input int u, input int m, input bit ovr, input bit pulse,
                      input bit started, input bit spur, input string tag);
    int len;
    int ld0;
    len = T + 1000 + (ovr ? 1000 : m + 3);
    ld0 = ldn[u];
    if (!started) begin
      if (pulse) inicio[u] = 1'b1;
      @(posedge ck); #1;
      inicio[u] = 1'b0;
    end
    for (int r = 0; r < len; r++) begin
      chk($sformatf("%s_r%0d", tag, r), 32'(obs(u)), 32'(exp_vec(r, m, ovr)));
      if (!ovr && r == T + 1000 + m - 1) vint[u] = 1'b1;
      if (spur) begin
        if (r == 0 || r == T + 300) inicio[u] = 1'b1;
        if (r == 2 || r == T + 302) inicio[u] = 1'b0;
        if (r == 1 || r == T + 500) vint[u] = 1'b1;
        if (r == 3 || r == T + 505) vint[u] = 1'b0;
      end
      if (r == len - 1) vint[u] = 1'b0;
      if (r < len - 1) begin
        @(posedge ck); #1;
      end
    end
    @(posedge ck); #1;
    if (u == 0) chk({tag, "_idle"}, 32'(obs(u)), 32'(exp_vec(len, m, ovr)));
    chk({tag, "_ldn"}, ldn[u] - ld0, ovr ? 0 : 1);
    if (!ovr) chk({tag, "_count"}, latched[u], (m + 2) % 1000);
  endtask

  initial begin
    int ld0;
    #1 rst_n = 1'b0;
    #2;
    chk("reset_u0", 32'(obs(0)), 32'h10);
    chk("reset_u1", 32'(obs(1)), 32'h10);
    repeat (3) @(posedge ck);
    @(negedge ck) rst_n = 1'b1;
    @(posedge ck); #1;

    conv(0, 437, 1'b0, 1'b1, 1'b0, 1'b0, "nominal");
    for (int k = 0; k < 2; k++)
      conv(0, int'($urandom_range(990, 1)), 1'b0, 1'b1, 1'b0, 1'b0, $sformatf("rand%0d", k));
    conv(0, 0, 1'b1, 1'b1, 1'b0, 1'b0, "overrange");
    conv(0, 437, 1'b0, 1'b1, 1'b0, 1'b1, "spurious");

    ld0 = ldn[0];
    inicio[0] = 1'b1;
    @(posedge ck); #1;
    inicio[0] = 1'b0;
    repeat (T + 500) @(posedge ck);
    #1;
    chk("pre_reset_integra", 32'(obs(0)), 32'h4A);
    #2 rst_n = 1'b0;
    #1 chk("async_reset", 32'(obs(0)), 32'h10);
    @(negedge ck) rst_n = 1'b1;
    @(posedge ck); #1;
    chk("post_reset_idle", 32'(obs(0)), 32'h10);
    chk("reset_no_ld", ldn[0] - ld0, 0);

    conv(0, int'($urandom_range(990, 1)), 1'b0, 1'b1, 1'b0, 1'b0, "after_reset");
    conv(0, 998, 1'b0, 1'b1, 1'b0, 1'b0, "simultaneous");

    conv(1, int'($urandom_range(990, 1)), 1'b0, 1'b1, 1'b0, 1'b0, "cont0");
    conv(1, int'($urandom_range(990, 1)), 1'b0, 1'b0, 1'b1, 1'b0, "cont1");
    conv(1, int'($urandom_range(990, 1)), 1'b0, 1'b0, 1'b1, 1'b0, "cont2");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
